// File: rtl/grain_keystream_gen.sv
// grain_keystream_gen: Grain-style keystream generator with an 80-bit LFSR and
// a 24-bit NFSR. A controller loads the seeds, runs INIT_ROUNDS warm-up shifts
// with the keystream bit fed back, then packs the serial keystream into
// OUT_W-bit words on a valid/ready handshake.
// Optional feature macro: GRAIN_KS_ENCRYPT_EN adds pt_word/ct_word, where
// ct_word = ks_word ^ pt_word.
module grain_keystream_gen #(
  parameter int OUT_W       = 8,
  parameter int INIT_ROUNDS = 160
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [79:0]      seed_l,
  input  logic [23:0]      seed_n,
  output logic             busy,
  output logic             init_done,
  output logic             seed_err,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [OUT_W-1:0] ks_word,
  output logic [79:0]      X_l,
  output logic [23:0]      X_n
`ifdef GRAIN_KS_ENCRYPT_EN
  ,
  input  logic [OUT_W-1:0] pt_word,
  output logic [OUT_W-1:0] ct_word
`endif
);

  // CW must be able to hold the value OUT_W itself (a full word).
  localparam int CW = $clog2(OUT_W + 1);
  // The round counter needs at least one bit even when warm-up is disabled.
  localparam int RW = (INIT_ROUNDS < 1) ? 1 : $clog2(INIT_ROUNDS + 1);
  localparam logic [RW-1:0] RND_LAST = RW'((INIT_ROUNDS > 0) ? (INIT_ROUNDS - 1) : 0);
  localparam logic [RW-1:0] RND_ONE  = RW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OUT_W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic             busy_r, init_done_r, seed_err_r;
  logic             busy_nxt_s, init_done_nxt_s, seed_err_nxt_s;
  logic [79:0]      l_r;
  logic [23:0]      n_r;
  logic [RW-1:0]    rnd_r;
  logic [CW-1:0]    cnt_r;
  logic             ks_valid_r;
  logic [OUT_W-1:0] ks_word_r;

  logic             seed_zero_s, load_s, reject_s, hold_s;
  logic             init_step_s, run_step_s;
  logic             fl_s, fn_s, h_s, z_s;
  logic             l_in_s, n_in_s;
  logic [CW-1:0]    idx_s, cnt_nxt_s;
  logic [OUT_W-1:0] word_nxt_s;

  assign busy      = busy_r;
  assign init_done = init_done_r;
  assign seed_err  = seed_err_r;
  assign ks_valid  = ks_valid_r;
  assign ks_word   = ks_word_r;
  assign X_l       = l_r;
  assign X_n       = n_r;

`ifdef GRAIN_KS_ENCRYPT_EN
  assign ct_word = ks_word_r ^ pt_word;
`else
  // Without the encrypt option only the raw keystream is exported.
`endif

  // Feedback taps, filter and keystream bit, all from the current state.
  always_comb begin
    fl_s = l_r[0] ^ l_r[13] ^ l_r[23] ^ l_r[38] ^ l_r[51] ^ l_r[62];
    fn_s = l_r[0] ^ n_r[0] ^ n_r[5] ^ (n_r[3] & n_r[9]) ^ (n_r[12] & n_r[17]);
    h_s  = l_r[0] ^ l_r[3] ^ n_r[0] ^ n_r[2] ^ (l_r[1] & l_r[2]) ^ (n_r[1] & l_r[5])
         ^ (n_r[3] & l_r[7]) ^ (l_r[8] & l_r[13] & n_r[5]);
    z_s  = h_s ^ n_r[0];
  end

  // Control qualifiers: start always wins, a zero LFSR seed is rejected.
  always_comb begin
    seed_zero_s = (seed_l == 80'd0);
    load_s      = start & ~seed_zero_s;
    reject_s    = start & seed_zero_s;
    hold_s      = ks_valid_r & ~ks_ready;
    init_step_s = ~start & (state_r == ST_INIT);
    run_step_s  = ~start & (state_r == ST_RUN) & ~hold_s;
  end

  // Bits entering the register MSBs: warm-up mixes z back in.
  always_comb begin
    if (init_step_s) begin
      l_in_s = fl_s ^ z_s;
      n_in_s = fn_s ^ z_s;
    end else begin
      l_in_s = fl_s;
      n_in_s = fn_s;
    end
  end

  // Packer: an accepted word restarts packing at bit 0 on the same edge.
  always_comb begin
    if (ks_valid_r) begin
      idx_s = {CW{1'b0}};
    end else begin
      idx_s = cnt_r;
    end
    cnt_nxt_s  = idx_s + CNT_ONE;
    word_nxt_s = ks_word_r;
    for (int i = 0; i < OUT_W; i++) begin
      if (CW'(i) == idx_s) begin
        word_nxt_s[i] = z_s;
      end else begin
        word_nxt_s[i] = ks_word_r[i];
      end
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (load_s) begin
      state_nxt_s = (INIT_ROUNDS == 0) ? ST_RUN : ST_INIT;
    end else if (reject_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_INIT: begin
          if (rnd_r == RND_LAST) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_INIT;
          end
        end
        ST_RUN:  state_nxt_s = ST_RUN;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM output decode, taken from the next state so the flops track it.
  always_comb begin
    seed_err_nxt_s = reject_s;
    case (state_nxt_s)
      ST_INIT: begin
        busy_nxt_s      = 1'b1;
        init_done_nxt_s = 1'b0;
      end
      ST_RUN: begin
        busy_nxt_s      = 1'b1;
        init_done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s      = 1'b0;
        init_done_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state register and registered status outputs.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      init_done_r <= 1'b0;
      seed_err_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      busy_r      <= busy_nxt_s;
      init_done_r <= init_done_nxt_s;
      seed_err_r  <= seed_err_nxt_s;
    end
  end

  // Datapath: load, warm-up shifts, run shifts with packing, or hold.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      l_r        <= 80'd0;
      n_r        <= 24'd0;
      rnd_r      <= {RW{1'b0}};
      cnt_r      <= {CW{1'b0}};
      ks_valid_r <= 1'b0;
      ks_word_r  <= {OUT_W{1'b0}};
    end else if (load_s) begin
      l_r        <= seed_l;
      n_r        <= seed_n;
      rnd_r      <= {RW{1'b0}};
      cnt_r      <= {CW{1'b0}};
      ks_valid_r <= 1'b0;
    end else if (reject_s) begin
      ks_valid_r <= 1'b0;
    end else if (init_step_s) begin
      l_r   <= {l_in_s, l_r[79:1]};
      n_r   <= {n_in_s, n_r[23:1]};
      rnd_r <= rnd_r + RND_ONE;
    end else if (run_step_s) begin
      l_r        <= {l_in_s, l_r[79:1]};
      n_r        <= {n_in_s, n_r[23:1]};
      ks_word_r  <= word_nxt_s;
      cnt_r      <= cnt_nxt_s;
      ks_valid_r <= (cnt_nxt_s == CNT_FULL);
    end else begin
      l_r <= l_r;
    end
  end

endmodule

// File: tb/tb_grain_keystream_gen.sv
// Directed bench for grain_keystream_gen: default instance (OUT_W=8,
// INIT_ROUNDS=160) plus a small instance (OUT_W=1, INIT_ROUNDS=0).
module tb_grain_keystream_gen;

  logic        Clk;
  logic        reset;
  logic        start, ks_ready;
  logic [79:0] seed_l;
  logic [23:0] seed_n;
  logic        busy, init_done, seed_err, ks_valid;
  logic [7:0]  ks_word;
  logic [79:0] X_l;
  logic [23:0] X_n;

  logic        start1, ks_ready1;
  logic [79:0] seed_l1;
  logic [23:0] seed_n1;
  logic        busy1, init_done1, seed_err1, ks_valid1;
  logic [0:0]  ks_word1;
  logic [79:0] X_l1;
  logic [23:0] X_n1;

`ifdef GRAIN_KS_ENCRYPT_EN
  logic [7:0]  pt_word, ct_word;
  logic [0:0]  pt_word1, ct_word1;
`endif

  int total = 0;
  int bad   = 0;

  logic [79:0] ml;
  logic [23:0] mn;
  logic [7:0]  w0, w1, w2, w3, w4;

  grain_keystream_gen #(.OUT_W(8), .INIT_ROUNDS(160)) dut (
    .Clk(Clk), .reset(reset), .start(start), .seed_l(seed_l), .seed_n(seed_n),
    .busy(busy), .init_done(init_done), .seed_err(seed_err), .ks_valid(ks_valid),
    .ks_ready(ks_ready), .ks_word(ks_word), .X_l(X_l), .X_n(X_n)
`ifdef GRAIN_KS_ENCRYPT_EN
    , .pt_word(pt_word), .ct_word(ct_word)
`endif
  );

  grain_keystream_gen #(.OUT_W(1), .INIT_ROUNDS(0)) dut1 (
    .Clk(Clk), .reset(reset), .start(start1), .seed_l(seed_l1), .seed_n(seed_n1),
    .busy(busy1), .init_done(init_done1), .seed_err(seed_err1), .ks_valid(ks_valid1),
    .ks_ready(ks_ready1), .ks_word(ks_word1), .X_l(X_l1), .X_n(X_n1)
`ifdef GRAIN_KS_ENCRYPT_EN
    , .pt_word(pt_word1), .ct_word(ct_word1)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick_n(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  function automatic logic ref_z(input logic [79:0] l, input logic [23:0] n);
    logic h;
    h = l[0] ^ l[3] ^ n[0] ^ n[2] ^ (l[1] & l[2]) ^ (n[1] & l[5]) ^ (n[3] & l[7])
      ^ (l[8] & l[13] & n[5]);
    return h ^ n[0];
  endfunction

  task automatic ref_step(input bit warm);
    logic z, a, b;
    z = ref_z(ml, mn);
    a = ml[0] ^ ml[13] ^ ml[23] ^ ml[38] ^ ml[51] ^ ml[62];
    b = ml[0] ^ mn[0] ^ mn[5] ^ (mn[3] & mn[9]) ^ (mn[12] & mn[17]);
    if (warm) begin
      a = a ^ z;
      b = b ^ z;
    end
    ml = {a, ml[79:1]};
    mn = {b, mn[23:1]};
  endtask

  task automatic ref_load(input logic [79:0] l, input logic [23:0] n);
    ml = l;
    mn = n;
    for (int i = 0; i < 160; i++) ref_step(1'b1);
  endtask

  task automatic ref_word(output logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      w[k] = ref_z(ml, mn);
      ref_step(1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ks_ready = 1'b0; seed_l = 80'd0; seed_n = 24'd0;
    start1 = 1'b0; ks_ready1 = 1'b0; seed_l1 = 80'd0; seed_n1 = 24'd0;
`ifdef GRAIN_KS_ENCRYPT_EN
    pt_word = 8'h00; pt_word1 = 1'b0;
`endif
    #12;
    reset = 1'b0;
    tick();
    chk("rst_busy", busy, 80'd0);
    chk("rst_init_done", init_done, 80'd0);
    chk("rst_seed_err", seed_err, 80'd0);
    chk("rst_valid", ks_valid, 80'd0);
    chk("rst_word", ks_word, 80'd0);
    chk("rst_xl", X_l, 80'd0);
    chk("rst_xn", X_n, 80'd0);

    // zero LFSR seed is rejected
    start = 1'b1; seed_l = 80'd0; seed_n = 24'hABCDE;
    tick();
    start = 1'b0;
    chk("rej_err_hi", seed_err, 80'd1);
    chk("rej_busy", busy, 80'd0);
    chk("rej_xl", X_l, 80'd0);
    chk("rej_valid", ks_valid, 80'd0);
    tick();
    chk("rej_err_lo", seed_err, 80'd0);
    tick_n(5);
    chk("rej_valid_later", ks_valid, 80'd0);
    chk("rej_busy_later", busy, 80'd0);

    // normal start at E0
    ks_ready = 1'b1;
    start = 1'b1; seed_l = 80'h0123_4567_89AB_CDEF_1357; seed_n = 24'h9ABCDE;
    tick();
    start = 1'b0;
    chk("load_xl", X_l, 80'h0123_4567_89AB_CDEF_1357);
    chk("load_xn", X_n, 80'h9ABCDE);
    chk("load_busy", busy, 80'd1);
    chk("load_init_done", init_done, 80'd0);
    chk("load_valid", ks_valid, 80'd0);
    ref_load(80'h0123_4567_89AB_CDEF_1357, 24'h9ABCDE);
    tick_n(159);
    chk("e159_init_done", init_done, 80'd0);
    tick();
    chk("e160_init_done", init_done, 80'd1);
    chk("e160_xl", X_l, ml);
    chk("e160_xn", X_n, mn);
    ref_word(w0);
    ref_word(w1);
    ref_word(w2);
    tick_n(7);
    chk("e167_valid", ks_valid, 80'd0);
    tick();
    chk("e168_valid", ks_valid, 80'd1);
    chk("e168_word", ks_word, w0);
    tick();
    chk("e169_valid", ks_valid, 80'd0);
    tick_n(7);
    chk("e176_valid", ks_valid, 80'd1);
    chk("e176_word", ks_word, w1);
    tick_n(8);
    chk("e184_valid", ks_valid, 80'd1);
    chk("e184_word", ks_word, w2);

    // backpressure: everything frozen for 10 cycles
    ks_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", ks_valid, 80'd1);
      chk("bp_word", ks_word, w2);
      chk("bp_xl", X_l, ml);
      chk("bp_xn", X_n, mn);
`ifdef GRAIN_KS_ENCRYPT_EN
      pt_word = (i < 5) ? 8'h00 : 8'hFF;
      #1;
      chk("enc_ct", ct_word, (i < 5) ? w2 : ~w2);
`endif
    end
    ks_ready = 1'b1;
    tick();
    chk("acc_valid", ks_valid, 80'd0);
    ref_word(w3);
    tick_n(7);
    chk("acc_next_valid", ks_valid, 80'd1);
    chk("acc_next_word", ks_word, w3);
    chk("acc_next_xl", X_l, ml);

    // restart mid-RUN with new seeds
    tick_n(3);
    start = 1'b1; seed_l = 80'hFEDC_BA98_7654_3210_0F0F; seed_n = 24'h13579B;
    tick();
    start = 1'b0;
    chk("rs_valid", ks_valid, 80'd0);
    chk("rs_xl", X_l, 80'hFEDC_BA98_7654_3210_0F0F);
    chk("rs_xn", X_n, 80'h13579B);
    chk("rs_init_done", init_done, 80'd0);
    chk("rs_busy", busy, 80'd1);
    ref_load(80'hFEDC_BA98_7654_3210_0F0F, 24'h13579B);
    ref_word(w4);
    tick_n(160);
    chk("rs_e160_init_done", init_done, 80'd1);
    tick_n(8);
    chk("rs_valid_word", ks_valid, 80'd1);
    chk("rs_word", ks_word, w4);
    chk("rs_xl_after", X_l, ml);

    // asynchronous reset mid-INIT
    start = 1'b1; seed_l = 80'h0123_4567_89AB_CDEF_1357; seed_n = 24'h9ABCDE;
    tick();
    start = 1'b0;
    tick_n(20);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_busy", busy, 80'd0);
    chk("ar_init_done", init_done, 80'd0);
    chk("ar_valid", ks_valid, 80'd0);
    chk("ar_word", ks_word, 80'd0);
    chk("ar_xl", X_l, 80'd0);
    chk("ar_xn", X_n, 80'd0);
    #1;
    reset = 1'b0;
    tick();
    chk("ar_idle_busy", busy, 80'd0);
    chk("ar_idle_xl", X_l, 80'd0);

    // OUT_W=1, INIT_ROUNDS=0 instance
    ks_ready1 = 1'b1;
    start1 = 1'b1; seed_l1 = 80'h1; seed_n1 = 24'h0;
    tick();
    start1 = 1'b0;
    chk("w1_load_xl", X_l1, 80'h1);
    chk("w1_load_valid", ks_valid1, 80'd0);
    chk("w1_load_init_done", init_done1, 80'd1);
    tick();
    chk("w1_valid", ks_valid1, 80'd1);
    chk("w1_word", ks_word1, 80'd1);
    chk("w1_xl", X_l1, 80'h8000_0000_0000_0000_0000);
    chk("w1_xn", X_n1, 80'h800000);
    tick();
    chk("w1_valid2", ks_valid1, 80'd1);
    chk("w1_word2", ks_word1, 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
